// File: rtl/bist_pattern_driver.sv
// bist_pattern_driver
//   Self-contained BIST engine for a single-output combinational CUT.
//   A 6-bit maximal-length LFSR (x^6+x^5+1) drives the CUT inputs. The CUT
//   response is folded into a serial signature register, one bit per applied
//   pattern. An optional all-zero pattern can be appended. The final
//   signature is compared against golden_sig.
//
//   Ports
//     clk, rst_n   rising-edge clock, asynchronous active-low reset
//     start        run request (honoured in IDLE/DONE only)
//     pause        freezes an active run (APPLY/ZERO) while high
//     abort        synchronous return to IDLE; signature/pat_cnt retained
//     golden_sig   expected signature
//     cut_po       CUT response to the pattern currently on cut_pi
//     cut_pi       pattern driven to the CUT (zero outside APPLY)
//     busy         run in progress (APPLY/ZERO)
//     done         run complete (DONE)
//     pass         done && signature == golden_sig
//     signature    compactor contents
//     pat_cnt      patterns captured in the current run
module bist_pattern_driver #(
    parameter int unsigned          PI_WIDTH     = 6,
    parameter logic [PI_WIDTH-1:0]  LFSR_SEED    = PI_WIDTH'(1),
    parameter int unsigned          NUM_PATTERNS = 63,
    parameter bit                   INCLUDE_ZERO = 1'b1,
    parameter int unsigned          SIG_WIDTH    = 16,
    parameter logic [SIG_WIDTH-1:0] SIG_POLY     = SIG_WIDTH'(16'h1021)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 pause,
    input  logic                 abort,
    input  logic [SIG_WIDTH-1:0] golden_sig,
    input  logic                 cut_po,
    output logic [PI_WIDTH-1:0]  cut_pi,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [SIG_WIDTH-1:0] signature,
    output logic [6:0]           pat_cnt
);

    localparam int unsigned CNT_WIDTH = 7;
    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(NUM_PATTERNS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        APPLY = 2'd1,
        ZERO  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [PI_WIDTH-1:0]    lfsr_q;
    logic [PI_WIDTH-1:0]    lfsr_d;
    logic [SIG_WIDTH-1:0]   sig_d;
    logic [CNT_WIDTH-1:0]   cnt_d;
    logic [PI_WIDTH-1:0]    cut_pi_d;
    logic                   busy_d;
    logic                   done_d;
    logic                   pass_d;
    logic [PI_WIDTH-1:0]    lfsr_step;
    logic [SIG_WIDTH-1:0]   sig_capture;

    // Serial signature compaction: shift, reduce by SIG_POLY, inject response bit.
    function automatic logic [SIG_WIDTH-1:0] compact(
        input logic [SIG_WIDTH-1:0] sig,
        input logic                 bit_in
    );
        compact = {sig[SIG_WIDTH-2:0], 1'b0}
                ^ (sig[SIG_WIDTH-1] ? SIG_POLY : '0)
                ^ {{(SIG_WIDTH-1){1'b0}}, bit_in};
    endfunction

    // Fibonacci LFSR, taps at x^6 and x^5.
    assign lfsr_step   = {lfsr_q[PI_WIDTH-2:0], lfsr_q[PI_WIDTH-1] ^ lfsr_q[PI_WIDTH-2]};
    assign sig_capture = compact(signature, cut_po);

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            lfsr_q    <= '0;
            signature <= '0;
            pat_cnt   <= '0;
            cut_pi    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            signature <= sig_d;
            pat_cnt   <= cnt_d;
            cut_pi    <= cut_pi_d;
            busy      <= busy_d;
            done      <= done_d;
            pass      <= pass_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d  = state_q;
        lfsr_d   = lfsr_q;
        sig_d    = signature;
        cnt_d    = pat_cnt;
        cut_pi_d = '0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        pass_d   = 1'b0;

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    lfsr_d  = LFSR_SEED;
                    sig_d   = '0;
                    cnt_d   = '0;
                    state_d = APPLY;
                end
            end
            APPLY: begin
                if (!pause) begin
                    sig_d  = sig_capture;
                    lfsr_d = lfsr_step;
                    cnt_d  = pat_cnt + CNT_WIDTH'(1);
                    if (pat_cnt == LAST_CNT) begin
                        state_d = INCLUDE_ZERO ? ZERO : DONE;
                    end
                end
            end
            ZERO: begin
                if (!pause) begin
                    sig_d   = sig_capture;
                    cnt_d   = pat_cnt + CNT_WIDTH'(1);
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort wins over everything; datapath keeps its contents for debug.
        if (abort) begin
            state_d = IDLE;
            lfsr_d  = lfsr_q;
            sig_d   = signature;
            cnt_d   = pat_cnt;
        end

        // Outputs follow the state being entered, so they stay registered.
        cut_pi_d = (state_d == APPLY) ? lfsr_d : '0;
        busy_d   = (state_d == APPLY) || (state_d == ZERO);
        done_d   = (state_d == DONE);
        pass_d   = done_d && (sig_d == golden_sig);
    end

endmodule

// File: tb/tb_bist_pattern_driver.sv
// Bench for bist_pattern_driver: a full-length instance (63 patterns + zero)
// and a short instance (2 patterns, no zero), checked against a reference
// LFSR / compactor model through expectation queues.
module tb_bist_pattern_driver;

    logic        clk;
    logic        rst_n;

    logic        start_a, pause_a, abort_a, cut_po_a;
    logic [15:0] golden_a;
    logic [5:0]  cut_pi_a;
    logic        busy_a, done_a, pass_a;
    logic [15:0] signature_a;
    logic [6:0]  pat_cnt_a;

    logic        start_b, pause_b, abort_b, cut_po_b;
    logic [15:0] golden_b;
    logic [5:0]  cut_pi_b;
    logic        busy_b, done_b, pass_b;
    logic [15:0] signature_b;
    logic [6:0]  pat_cnt_b;

    int          cut_mode;
    int          n_pass;
    int          n_total;
    logic [5:0]  exp_q [$];
    logic [5:0]  first_pi [7];

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        pass;
        logic [5:0]  pi;
        logic [6:0]  cnt;
        logic [15:0] sig;
    } obs_t;

    obs_t        sb_q [$];

    bist_pattern_driver #(
        .PI_WIDTH(6), .LFSR_SEED(6'h01), .NUM_PATTERNS(63),
        .INCLUDE_ZERO(1'b1), .SIG_WIDTH(16), .SIG_POLY(16'h1021)
    ) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .pause(pause_a),
        .abort(abort_a), .golden_sig(golden_a), .cut_po(cut_po_a),
        .cut_pi(cut_pi_a), .busy(busy_a), .done(done_a), .pass(pass_a),
        .signature(signature_a), .pat_cnt(pat_cnt_a)
    );

    bist_pattern_driver #(
        .PI_WIDTH(6), .LFSR_SEED(6'h01), .NUM_PATTERNS(2),
        .INCLUDE_ZERO(1'b0), .SIG_WIDTH(16), .SIG_POLY(16'h1021)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .pause(pause_b),
        .abort(abort_b), .golden_sig(golden_b), .cut_po(cut_po_b),
        .cut_pi(cut_pi_b), .busy(busy_b), .done(done_b), .pass(pass_b),
        .signature(signature_b), .pat_cnt(pat_cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural CUT: constant 0, constant 1, or a parity function of the pattern.
    function automatic logic cut_fn(input int mode, input logic [5:0] pat);
        if (mode == 0) return 1'b0;
        if (mode == 1) return 1'b1;
        return ^(pat & 6'h2D);
    endfunction

    // Reference compactor written as polynomial division by x^16+x^12+x^5+1.
    function automatic logic [15:0] ref_compact(input logic [15:0] s, input logic b);
        logic msb;
        msb = s[15];
        s = s << 1;
        if (msb) s = s ^ 16'h1021;
        s[0] = s[0] ^ b;
        return s;
    endfunction

    always_comb cut_po_a = cut_fn(cut_mode, cut_pi_a);

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Full run on instance A with optional pause window; model drives all expectations.
    task automatic run_a(input int mode, input int p_after, input int p_len,
                         output logic [15:0] final_sig, output int cycles);
        logic [5:0]  l;
        logic [5:0]  pat;
        logic [15:0] esig;
        int          ecnt, caps, pcyc, guard;
        cut_mode = mode;
        exp_q.delete();
        l = 6'h01;
        for (int i = 0; i < 63; i++) begin
            exp_q.push_back(l);
            l = {l[4:0], l[5] ^ l[4]};
        end
        exp_q.push_back(6'h00);
        esig = 16'h0; ecnt = 0; caps = 0; pcyc = 0; guard = 0;
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        while (exp_q.size() != 0 && guard < 300) begin
            n_total++; if (cut_pi_a !== exp_q[0]) $display("FAIL run_cut_pi: got %h want %h (capture %0d)", cut_pi_a, exp_q[0], caps); else n_pass++;
            n_total++; if (signature_a !== esig) $display("FAIL run_signature: got %h want %h (capture %0d)", signature_a, esig, caps); else n_pass++;
            n_total++; if (pat_cnt_a !== 7'(ecnt)) $display("FAIL run_pat_cnt: got %0d want %0d", pat_cnt_a, ecnt); else n_pass++;
            n_total++; if ({busy_a, done_a} !== 2'b10) $display("FAIL run_busy_done: got %b want 10", {busy_a, done_a}); else n_pass++;
            if (caps < 7) first_pi[caps] = cut_pi_a;
            if (caps == p_after && pcyc < p_len) begin
                pause_a = 1'b1;
                pcyc++;
            end else begin
                pause_a = 1'b0;
                pat = exp_q.pop_front();
                esig = ref_compact(esig, cut_fn(mode, pat));
                ecnt++;
                caps++;
            end
            @(negedge clk);
            guard++;
        end
        pause_a = 1'b0;
        n_total++; if (exp_q.size() != 0) $display("FAIL run_timeout: %0d patterns left want 0", exp_q.size()); else n_pass++;
        n_total++; if ({busy_a, done_a} !== 2'b01) $display("FAIL end_busy_done: got %b want 01", {busy_a, done_a}); else n_pass++;
        n_total++; if (signature_a !== esig) $display("FAIL end_signature: got %h want %h", signature_a, esig); else n_pass++;
        n_total++; if (pat_cnt_a !== 7'(ecnt)) $display("FAIL end_pat_cnt: got %0d want %0d", pat_cnt_a, ecnt); else n_pass++;
        n_total++; if (cut_pi_a !== 6'h00) $display("FAIL end_cut_pi: got %h want 00", cut_pi_a); else n_pass++;
        n_total++; if (pass_a !== (esig == golden_a)) $display("FAIL end_pass: got %b want %b", pass_a, (esig == golden_a)); else n_pass++;
        final_sig = esig;
        cycles = guard;
    endtask

    task automatic test_reset();
        #23;
        n_total++; if ({cut_pi_a, busy_a, done_a, pass_a, signature_a, pat_cnt_a} !== '0) $display("FAIL reset_a: got %h want 0", {cut_pi_a, busy_a, done_a, pass_a, signature_a, pat_cnt_a}); else n_pass++;
        n_total++; if ({cut_pi_b, busy_b, done_b, pass_b, signature_b, pat_cnt_b} !== '0) $display("FAIL reset_b: got %h want 0", {cut_pi_b, busy_b, done_b, pass_b, signature_b, pat_cnt_b}); else n_pass++;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        n_total++; if ({busy_a, done_a, cut_pi_a} !== '0) $display("FAIL idle_after_reset: got %h want 0", {busy_a, done_a, cut_pi_a}); else n_pass++;
    endtask

    task automatic test_basic();
        logic [5:0]  ref7 [7];
        logic [15:0] s;
        int          cyc;
        ref7 = '{6'h01, 6'h02, 6'h04, 6'h08, 6'h10, 6'h21, 6'h03};
        golden_a = 16'h0000;
        run_a(0, -1, 0, s, cyc);
        for (int i = 0; i < 7; i++) begin
            n_total++; if (first_pi[i] !== ref7[i]) $display("FAIL basic_first_patterns[%0d]: got %h want %h", i, first_pi[i], ref7[i]); else n_pass++;
        end
        n_total++; if (cyc !== 64) $display("FAIL basic_latency: got %0d want 64", cyc); else n_pass++;
        n_total++; if (signature_a !== 16'h0000) $display("FAIL basic_signature: got %h want 0000", signature_a); else n_pass++;
        n_total++; if (pat_cnt_a !== 7'd64) $display("FAIL basic_pat_cnt: got %0d want 64", pat_cnt_a); else n_pass++;
        n_total++; if (pass_a !== 1'b1) $display("FAIL basic_pass: got %b want 1", pass_a); else n_pass++;
    endtask

    // Cycle table on instance B: start while busy, pause in DONE/IDLE, abort priority.
    task automatic test_sequence();
        logic [2:0] stim [12];
        obs_t       rows [12];
        obs_t       e, o;
        cut_po_b = 1'b1;
        golden_b = 16'h0003;
        stim = '{3'b100, 3'b100, 3'b000, 3'b110, 3'b010, 3'b011,
                 3'b010, 3'b101, 3'b100, 3'b000, 3'b000, 3'b001};
        rows = '{'{1'b1, 1'b0, 1'b0, 6'h01, 7'd0, 16'h0000},
                 '{1'b1, 1'b0, 1'b0, 6'h02, 7'd1, 16'h0001},
                 '{1'b0, 1'b1, 1'b1, 6'h00, 7'd2, 16'h0003},
                 '{1'b1, 1'b0, 1'b0, 6'h01, 7'd0, 16'h0000},
                 '{1'b1, 1'b0, 1'b0, 6'h01, 7'd0, 16'h0000},
                 '{1'b0, 1'b0, 1'b0, 6'h00, 7'd0, 16'h0000},
                 '{1'b0, 1'b0, 1'b0, 6'h00, 7'd0, 16'h0000},
                 '{1'b0, 1'b0, 1'b0, 6'h00, 7'd0, 16'h0000},
                 '{1'b1, 1'b0, 1'b0, 6'h01, 7'd0, 16'h0000},
                 '{1'b1, 1'b0, 1'b0, 6'h02, 7'd1, 16'h0001},
                 '{1'b0, 1'b1, 1'b1, 6'h00, 7'd2, 16'h0003},
                 '{1'b0, 1'b0, 1'b0, 6'h00, 7'd2, 16'h0003}};
        @(negedge clk);
        for (int i = 0; i < 12; i++) begin
            {start_b, pause_b, abort_b} = stim[i];
            sb_q.push_back(rows[i]);
            @(negedge clk);
            e = sb_q.pop_front();
            o = '{busy_b, done_b, pass_b, cut_pi_b, pat_cnt_b, signature_b};
            n_total++; if (o !== e) $display("FAIL sequence_row%0d: got %h want %h", i, o, e); else n_pass++;
        end
        {start_b, pause_b, abort_b} = 3'b000;
    endtask

    task automatic test_pass_fail();
        golden_b = 16'h0004;
        @(negedge clk); start_b = 1'b1;
        @(negedge clk); start_b = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_total++; if ({done_b, pass_b} !== 2'b10) $display("FAIL golden_mismatch: got done,pass=%b want 10", {done_b, pass_b}); else n_pass++;
        n_total++; if (signature_b !== 16'h0003) $display("FAIL short_signature: got %h want 0003", signature_b); else n_pass++;
        golden_b = 16'h0003;
        @(negedge clk);
        n_total++; if ({done_b, pass_b} !== 2'b11) $display("FAIL golden_update: got done,pass=%b want 11", {done_b, pass_b}); else n_pass++;
    endtask

    task automatic test_pause();
        logic [15:0] s;
        int          cyc;
        run_a(0, 3, 5, s, cyc);
        n_total++; if (cyc !== 69) $display("FAIL pause_latency: got %0d want 69", cyc); else n_pass++;
        n_total++; if (first_pi[3] !== 6'h08) $display("FAIL pause_held_pattern: got %h want 08", first_pi[3]); else n_pass++;
        n_total++; if (signature_a !== 16'h0000) $display("FAIL pause_signature: got %h want 0000", signature_a); else n_pass++;
    endtask

    task automatic test_cut_function();
        logic [15:0] s;
        int          cyc;
        golden_a = 16'h0000;
        run_a(2, 10, 2, s, cyc);
        n_total++; if (cyc !== 66) $display("FAIL cut_fn_latency: got %0d want 66", cyc); else n_pass++;
    endtask

    task automatic test_abort();
        logic [15:0] s;
        int          cyc, guard;
        cut_mode = 2;
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        guard = 0;
        while (pat_cnt_a !== 7'd10 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        n_total++; if (pat_cnt_a !== 7'd10) $display("FAIL abort_reach10: got %0d want 10", pat_cnt_a); else n_pass++;
        abort_a = 1'b1;
        @(negedge clk); abort_a = 1'b0;
        n_total++; if ({busy_a, done_a, pass_a, cut_pi_a} !== '0) $display("FAIL abort_outputs: got %h want 0", {busy_a, done_a, pass_a, cut_pi_a}); else n_pass++;
        n_total++; if (pat_cnt_a !== 7'd10) $display("FAIL abort_pat_cnt: got %0d want 10", pat_cnt_a); else n_pass++;
        @(negedge clk);
        n_total++; if ({busy_a, pat_cnt_a} !== {1'b0, 7'd10}) $display("FAIL abort_idle_hold: got %h want 00a", {busy_a, pat_cnt_a}); else n_pass++;
        run_a(2, -1, 0, s, cyc);
    endtask

    task automatic test_reset_midrun();
        logic [15:0] s;
        int          cyc;
        cut_mode = 1;
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        repeat (5) @(negedge clk);
        n_total++; if (busy_a !== 1'b1) $display("FAIL midrun_busy: got %b want 1", busy_a); else n_pass++;
        rst_n = 1'b0;
        #1;
        n_total++; if ({cut_pi_a, busy_a, done_a, pass_a, signature_a, pat_cnt_a} !== '0) $display("FAIL midrun_reset: got %h want 0", {cut_pi_a, busy_a, done_a, pass_a, signature_a, pat_cnt_a}); else n_pass++;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        n_total++; if ({busy_a, done_a} !== 2'b00) $display("FAIL midrun_no_done: got %b want 00", {busy_a, done_a}); else n_pass++;
        run_a(1, -1, 0, s, cyc);
    endtask

    task automatic test_back_to_back();
        logic [15:0] s1, s2;
        int          cyc;
        run_a(2, -1, 0, s1, cyc);
        golden_a = s1;
        run_a(2, -1, 0, s2, cyc);
        n_total++; if (signature_a !== s1) $display("FAIL rerun_signature: got %h want %h", signature_a, s1); else n_pass++;
        n_total++; if (pass_a !== 1'b1) $display("FAIL rerun_pass: got %b want 1", pass_a); else n_pass++;
    endtask

    initial begin
        n_pass = 0; n_total = 0; cut_mode = 0;
        rst_n = 1'b0;
        start_a = 1'b0; pause_a = 1'b0; abort_a = 1'b0; golden_a = 16'h0;
        start_b = 1'b0; pause_b = 1'b0; abort_b = 1'b0; golden_b = 16'h0; cut_po_b = 1'b1;
        test_reset();
        test_basic();
        test_sequence();
        test_pass_fail();
        test_pause();
        test_cut_function();
        test_abort();
        test_reset_midrun();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
